// File: rtl/ahblite_lcd_8080.sv
// AHB-lite slave driving an 8080 parallel LCD: manual pin mode or FIFO-fed strobe engine.
// Register reads zero-wait; a push into a full FIFO stalls HREADYOUT in engine mode, drops with OVF in manual mode.
module ahblite_lcd_8080 #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TWRL_RST   = 1,
    parameter int TWRH_RST   = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [3:0]        HPROT,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    output logic              HRESP,
    output logic              LCD_CS,
    output logic              LCD_RS,
    output logic              LCD_WR,
    output logic              LCD_RD,
    output logic              LCD_RST,
    output logic [DATA_W-1:0] LCD_DATA,
    output logic              LCD_BL_CTR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_MAN    = 4'd1;
    localparam logic [3:0] A_MDATA  = 4'd2;
    localparam logic [3:0] A_TIMING = 4'd3;
    localparam logic [3:0] A_CMD    = 4'd4;
    localparam logic [3:0] A_DAT    = 4'd5;
    localparam logic [3:0] A_STATUS = 4'd6;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WRLO, ST_WRHI} state_t;

    logic              dp_vld_q, dp_vld_d;
    logic              dp_wr_q, dp_wr_d;
    logic [3:0]        dp_addr_q, dp_addr_d;
    logic              mode_q, mode_d;
    logic              rst_q, rst_d;
    logic              bl_q, bl_d;
    logic              flush_q, flush_d;
    logic [3:0]        man_q, man_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic [7:0]        wrl_q, wrl_d;
    logic [7:0]        wrh_q, wrh_d;
    logic              ovf_q, ovf_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W:0]   mem_d [FIFO_DEPTH];
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        wrh_act_q, wrh_act_d;
    logic              rs_q, rs_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              pop;
    logic              avail;
    logic [DATA_W:0]   head;
    logic              fifo_full;
    logic              push_req;
    logic              stall;
    logic              drop;
    logic              push;
    logic              wr_fire;
    logic [AW-1:0]     widx;
    logic [31:0]       rdata;
    logic              eng;
    logic              unused_ok;

    assign unused_ok = ^{HSIZE, HPROT, HADDR[31:6], HADDR[1:0], HTRANS[0], HWDATA};
    assign HRESP     = 1'b0;

    // Engine: a pop happens in IDLE or at the end of WRHI; flushed entries are never popped.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wrh_act_d = wrh_act_q;
        rs_d      = rs_q;
        data_d    = data_q;
        pop       = 1'b0;
        avail     = mode_q & (level_q != '0) & ~flush_q;
        head      = mem_q[rptr_q];
        case (state_q)
            ST_IDLE: begin
                if (avail) begin
                    pop     = 1'b1;
                    rs_d    = head[DATA_W];
                    data_d  = head[DATA_W-1:0];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d     = wrl_q;
                wrh_act_d = wrh_q;
                state_d   = ST_WRLO;
            end
            ST_WRLO: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = wrh_act_q;
                    state_d = ST_WRHI;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_WRHI: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (avail) begin
                    pop     = 1'b1;
                    rs_d    = head[DATA_W];
                    data_d  = head[DATA_W-1:0];
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus side: data-phase decode, register writes, FIFO push/flush.
    always_comb begin
        fifo_full = (level_q == LW'(FIFO_DEPTH));
        push_req  = dp_vld_q & dp_wr_q & ((dp_addr_q == A_CMD) | (dp_addr_q == A_DAT));
        stall     = push_req & fifo_full & mode_q & ~pop & ~flush_q;
        drop      = push_req & fifo_full & ~mode_q & ~pop & ~flush_q;
        push      = push_req & ~stall & ~drop;
        wr_fire   = dp_vld_q & dp_wr_q & ~stall;

        dp_vld_d  = dp_vld_q;
        dp_wr_d   = dp_wr_q;
        dp_addr_d = dp_addr_q;
        if (HREADY) begin
            dp_vld_d  = HSEL & HTRANS[1];
            dp_wr_d   = HWRITE;
            dp_addr_d = HADDR[5:2];
        end

        mode_d  = mode_q;
        rst_d   = rst_q;
        bl_d    = bl_q;
        flush_d = 1'b0;
        man_d   = man_q;
        mdata_d = mdata_q;
        wrl_d   = wrl_q;
        wrh_d   = wrh_q;
        ovf_d   = ovf_q;
        if (wr_fire) begin
            case (dp_addr_q)
                A_CTRL: begin
                    mode_d  = HWDATA[0];
                    rst_d   = HWDATA[1];
                    bl_d    = HWDATA[2];
                    flush_d = HWDATA[4];
                end
                A_MAN:    man_d   = HWDATA[3:0];
                A_MDATA:  mdata_d = HWDATA[DATA_W-1:0];
                A_TIMING: begin
                    wrl_d = HWDATA[7:0];
                    wrh_d = HWDATA[15:8];
                end
                A_STATUS: if (HWDATA[3]) ovf_d = 1'b0;
                default: ;
            endcase
        end
        if (drop) ovf_d = 1'b1;

        mem_d = mem_q;
        if (flush_q) begin
            // A push landing in the flush cycle becomes the sole entry.
            widx    = '0;
            wptr_d  = push ? AW'(1) : '0;
            rptr_d  = '0;
            level_d = push ? LW'(1) : '0;
        end else begin
            widx    = wptr_q;
            wptr_d  = wptr_q + AW'(push);
            rptr_d  = rptr_q + AW'(pop);
            level_d = level_q + LW'(push) - LW'(pop);
        end
        if (push) mem_d[widx] = {dp_addr_q == A_DAT, HWDATA[DATA_W-1:0]};
    end

    always_comb begin
        rdata = '0;
        case (dp_addr_q)
            A_CTRL:   rdata[2:0]        = {bl_q, rst_q, mode_q};
            A_MAN:    rdata[3:0]        = man_q;
            A_MDATA:  rdata[DATA_W-1:0] = mdata_q;
            A_TIMING: rdata[15:0]       = {wrh_q, wrl_q};
            A_STATUS: begin
                rdata[0]      = (state_q != ST_IDLE);
                rdata[1]      = fifo_full;
                rdata[2]      = (level_q == '0);
                rdata[3]      = ovf_q;
                rdata[8 +: LW] = level_q;
            end
            default: ;
        endcase
        HRDATA    = rdata;
        HREADYOUT = ~stall;
    end

    // Pins stay with the engine until an in-flight beat finishes after MODE drops.
    always_comb begin
        eng        = mode_q | (state_q != ST_IDLE);
        LCD_CS     = eng ? (state_q == ST_IDLE) : man_q[0];
        LCD_RS     = eng ? rs_q                 : man_q[1];
        LCD_WR     = eng ? (state_q != ST_WRLO) : man_q[2];
        LCD_RD     = eng ? 1'b1                 : man_q[3];
        LCD_DATA   = eng ? data_q               : mdata_q;
        LCD_RST    = rst_q;
        LCD_BL_CTR = bl_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_vld_q  <= 1'b0;
            dp_wr_q   <= 1'b0;
            dp_addr_q <= '0;
            mode_q    <= 1'b0;
            rst_q     <= 1'b0;
            bl_q      <= 1'b0;
            flush_q   <= 1'b0;
            man_q     <= 4'b1101;
            mdata_q   <= '0;
            wrl_q     <= 8'(TWRL_RST);
            wrh_q     <= 8'(TWRH_RST);
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wrh_act_q <= '0;
            rs_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            dp_vld_q  <= dp_vld_d;
            dp_wr_q   <= dp_wr_d;
            dp_addr_q <= dp_addr_d;
            mode_q    <= mode_d;
            rst_q     <= rst_d;
            bl_q      <= bl_d;
            flush_q   <= flush_d;
            man_q     <= man_d;
            mdata_q   <= mdata_d;
            wrl_q     <= wrl_d;
            wrh_q     <= wrh_d;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            mem_q     <= mem_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wrh_act_q <= wrh_act_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
        end
    end
endmodule

// File: tb/tb_ahblite_lcd_8080.sv
// Directed bench for ahblite_lcd_8080: register table plus hand-built engine, stall, overflow and flush sequences.
module tb_ahblite_lcd_8080;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'd2;
    logic [3:0]  HPROT = 4'd1;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_BL_CTR;
    logic [15:0] LCD_DATA;

    assign HREADY = HREADYOUT;

    ahblite_lcd_8080 dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
        .LCD_RST(LCD_RST), .LCD_DATA(LCD_DATA), .LCD_BL_CTR(LCD_BL_CTR)
    );

    always #5 HCLK = ~HCLK;

    int errs = 0;
    int checks = 0;

    // {RST, BL, CS, RS, WR, RD, DATA}
    localparam logic [21:0] P_RST = 22'h0B0000;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [21:0] exp_pins;
    } vec_t;

    vec_t vecs[20];

    logic        rec = 1'b0;
    logic [18:0] trace[$];
    logic        exp_rs[16];
    logic [15:0] exp_dat[16];

    always @(negedge HCLK) if (rec) trace.push_back({LCD_CS, LCD_RS, LCD_WR, LCD_DATA});

    function automatic logic [21:0] pins();
        return {LCD_RST, LCD_BL_CTR, LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d, output int waits);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        waits = 0;
        @(negedge HCLK);
        while (!HREADYOUT && waits < 300) begin
            waits++;
            @(negedge HCLK);
        end
        if (waits >= 300) chk("write_timeout", 32'(waits), 32'd0);
        @(posedge HCLK); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int w;
        ahb_write(a, d, w);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    // Expected beat: SETUP (WR=1), WRL+1 cycles WR=0, WRH+1 cycles WR=1, CS low throughout.
    task automatic check_beats(input string nm, input int nb, input int wrl, input int wrh);
        int start, blen, bad, low, idx;
        logic [18:0] e;
        start = -1;
        low = 0;
        foreach (trace[i]) begin
            if (trace[i][18] == 1'b0) begin
                low++;
                if (start < 0) start = i;
            end
        end
        blen = wrl + wrh + 3;
        chk({nm, " cs_low_cycles"}, 32'(low), 32'(nb * blen));
        if (start < 0) start = 0;
        for (int b = 0; b < nb; b++) begin
            bad = 0;
            for (int p = 0; p < blen; p++) begin
                idx = start + b * blen + p;
                e = {1'b0, exp_rs[b], ((p >= 1) && (p <= wrl + 1)) ? 1'b0 : 1'b1, exp_dat[b]};
                if (idx >= trace.size()) bad++;
                else if (trace[idx] !== e) bad++;
            end
            chk($sformatf("%s beat%0d bad_cycles", nm, b), 32'(bad), 32'd0);
        end
        idx = start + nb * blen;
        chk({nm, " cs_high_after"}, (idx < trace.size()) ? 32'(trace[idx][18]) : 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int w;
        int n;
        int sum_w;

        vecs[0]  = '{1'b0, 32'h18, 32'h0,        32'h4,      22'h0B0000};
        vecs[1]  = '{1'b0, 32'h00, 32'h0,        32'h0,      22'h0B0000};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,        32'hD,      22'h0B0000};
        vecs[3]  = '{1'b0, 32'h0C, 32'h0,        32'h0101,   22'h0B0000};
        vecs[4]  = '{1'b0, 32'h1C, 32'h0,        32'h0,      22'h0B0000};
        vecs[5]  = '{1'b0, 32'h10, 32'h0,        32'h0,      22'h0B0000};
        vecs[6]  = '{1'b1, 32'h08, 32'h1234A5A5, 32'h0,      22'h0BA5A5};
        vecs[7]  = '{1'b1, 32'h04, 32'hD,        32'h0,      22'h0BA5A5};
        vecs[8]  = '{1'b0, 32'h04, 32'h0,        32'hD,      22'h0BA5A5};
        vecs[9]  = '{1'b0, 32'h08, 32'h0,        32'hA5A5,   22'h0BA5A5};
        vecs[10] = '{1'b1, 32'h04, 32'h2,        32'h0,      22'h04A5A5};
        vecs[11] = '{1'b0, 32'h04, 32'h0,        32'h2,      22'h04A5A5};
        vecs[12] = '{1'b1, 32'h00, 32'h16,       32'h0,      22'h34A5A5};
        vecs[13] = '{1'b0, 32'h00, 32'h0,        32'h6,      22'h34A5A5};
        vecs[14] = '{1'b1, 32'h04, 32'hFFFFFFFD, 32'h0,      22'h3BA5A5};
        vecs[15] = '{1'b1, 32'h0C, 32'hFFFF0203, 32'h0,      22'h3BA5A5};
        vecs[16] = '{1'b0, 32'h0C, 32'h0,        32'h0203,   22'h3BA5A5};
        vecs[17] = '{1'b0, 32'h18, 32'h0,        32'h4,      22'h3BA5A5};
        vecs[18] = '{1'b1, 32'h1C, 32'hFFFFFFFF, 32'h0,      22'h3BA5A5};
        vecs[19] = '{1'b0, 32'h08, 32'h0,        32'hA5A5,   22'h3BA5A5};

        // Reset state and register table
        apply_reset();
        chk("reset_pins", 32'(pins()), 32'(P_RST));
        chk("reset_hreadyout", 32'(HREADYOUT), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                ahb_read(vecs[i].addr, rd);
                chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            end
            chk($sformatf("vec%0d pins", i), 32'(pins()), 32'(vecs[i].exp_pins));
        end

        // Async reset in the middle of WRLO
        apply_reset();
        wr(32'h00, 32'h7);
        wr(32'h10, 32'h2C);
        n = 0;
        while (LCD_WR !== 1'b0 && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        chk("wrlo_reached", 32'(n < 50), 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        chk("midbeat_reset_pins", 32'(pins()), 32'(P_RST));
        chk("midbeat_reset_hreadyout", 32'(HREADYOUT), 32'd1);
        apply_reset();
        ahb_read(32'h18, rd);
        chk("midbeat_reset_status", rd, 32'h4);

        // Two back-to-back beats with TIMING 0x0102
        apply_reset();
        wr(32'h00, 32'h1);
        wr(32'h0C, 32'h0102);
        trace.delete();
        rec = 1'b1;
        wr(32'h10, 32'h2C);
        wr(32'h14, 32'hF800);
        cycles(30);
        rec = 1'b0;
        exp_rs[0] = 1'b0; exp_dat[0] = 16'h002C;
        exp_rs[1] = 1'b1; exp_dat[1] = 16'hF800;
        check_beats("two_beats", 2, 2, 1);

        // Full FIFO in engine mode: first word is popped at once, so the 10th push is the one that stalls
        apply_reset();
        wr(32'h00, 32'h1);
        wr(32'h0C, 32'h1414);
        trace.delete();
        rec = 1'b1;
        sum_w = 0;
        for (int k = 0; k < 10; k++) begin
            ahb_write((k % 2) ? 32'h14 : 32'h10, 32'h100 + 32'(k), w);
            if (k < 9) sum_w += w;
            exp_rs[k] = 1'(k % 2);
            exp_dat[k] = 16'h100 + 16'(k);
        end
        chk("stall_prior_waits", 32'(sum_w), 32'd0);
        chk("stall_waits", 32'(w), 32'd26);
        cycles(450);
        rec = 1'b0;
        check_beats("stall_order", 10, 20, 20);

        // Manual mode overflow, then drain to confirm the dropped word never entered
        apply_reset();
        for (int k = 0; k < 8; k++) wr(32'h14, 32'(k));
        ahb_write(32'h14, 32'h99, w);
        chk("ovf_no_stall", 32'(w), 32'd0);
        chk("ovf_pins_manual", 32'(LCD_CS), 32'd1);
        ahb_read(32'h18, rd);
        chk("ovf_status", rd, 32'h80A);
        wr(32'h18, 32'h8);
        ahb_read(32'h18, rd);
        chk("ovf_w1c_status", rd, 32'h802);
        trace.delete();
        rec = 1'b1;
        wr(32'h00, 32'h1);
        cycles(50);
        rec = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_rs[k] = 1'b1;
            exp_dat[k] = 16'(k);
        end
        check_beats("ovf_drain", 8, 1, 1);

        // FLUSH during first WRLO
        apply_reset();
        wr(32'h00, 32'h1);
        wr(32'h0C, 32'h0A0A);
        trace.delete();
        rec = 1'b1;
        for (int k = 0; k < 4; k++) wr(32'h14, 32'h11 + 32'(k));
        wr(32'h00, 32'h11);
        cycles(60);
        rec = 1'b0;
        exp_rs[0] = 1'b1; exp_dat[0] = 16'h11;
        check_beats("flush", 1, 10, 10);
        ahb_read(32'h18, rd);
        chk("flush_status", rd, 32'h4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
